// File: rtl/ram_pipe.sv
// ---------------------------------------------------------------------------
// ram_pipe
//
// Behavioural memory model for the Vortex memory request/response interface.
// Reads see a fixed latency of LATENCY cycles through a non-stalling pipeline
// feeding a bounded response FIFO. A credit counter holds back new requests
// so the FIFO can never overflow, which keeps the pipeline free of stalls.
// Writes are applied at the accepting edge with per-byte enables and produce
// no response.
//
// Optional feature (compile-time macro RAM_DONE_MONITOR_EN):
//   When defined, a sticky registered flag done_o rises the cycle after the
//   low 32 bits of line DONE_ADDR hold 32'h1. When undefined, done_o is tied
//   to 0 and no comparator exists.
//
// Parameters:
//   RAM_ADDR_BITS   line-address width; 2**RAM_ADDR_BITS lines of storage
//   DATA_WIDTH      line width in bits (multiple of 32)
//   TAG_WIDTH       request/response tag width
//   LATENCY         read latency, accept edge to response valid (1..16)
//   RSP_FIFO_DEPTH  maximum outstanding reads (power of two, >= 2)
//   DONE_ADDR       line index watched by the completion monitor
//
// Ports:
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   mem_req_valid_i   request valid
//   mem_req_rw_i      1 = write, 0 = read
//   mem_req_byteen_i  write byte enables
//   mem_req_addr_i    line address
//   mem_req_data_i    write data
//   mem_req_tag_i     request tag
//   mem_req_ready_o   request ready (credit available)
//   mem_rsp_valid_o   read response valid (FIFO not empty)
//   mem_rsp_data_o    read data at FIFO head, 0 when empty
//   mem_rsp_tag_o     tag at FIFO head, 0 when empty
//   mem_rsp_ready_i   response ready
//   done_o            completion flag
// ---------------------------------------------------------------------------
module ram_pipe #(
  parameter int RAM_ADDR_BITS  = 9,
  parameter int DATA_WIDTH     = 512,
  parameter int TAG_WIDTH      = 8,
  parameter int LATENCY        = 4,
  parameter int RSP_FIFO_DEPTH = 8,
  parameter int DONE_ADDR      = 496
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      mem_req_valid_i,
  input  logic                      mem_req_rw_i,
  input  logic [DATA_WIDTH/8-1:0]   mem_req_byteen_i,
  input  logic [RAM_ADDR_BITS-1:0]  mem_req_addr_i,
  input  logic [DATA_WIDTH-1:0]     mem_req_data_i,
  input  logic [TAG_WIDTH-1:0]      mem_req_tag_i,
  output logic                      mem_req_ready_o,

  output logic                      mem_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]     mem_rsp_data_o,
  output logic [TAG_WIDTH-1:0]      mem_rsp_tag_o,
  input  logic                      mem_rsp_ready_i,

  output logic                      done_o
);

  localparam int LINES = 1 << RAM_ADDR_BITS;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_INC = PTR_W'(1);

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic req_fire;
  logic rd_accept;
  logic wr_accept;
  logic pop;

  assign req_fire  = mem_req_valid_i && mem_req_ready_o;
  assign rd_accept = req_fire && !mem_req_rw_i;
  assign wr_accept = req_fire &&  mem_req_rw_i;
  assign pop       = mem_rsp_valid_o && mem_rsp_ready_i;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the memory array has no reset branch; contents must survive rst_i
  // and a reset loop over every line would not map onto RAM macros.
  logic [DATA_WIDTH-1:0] mem_array [0:LINES-1];

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_req_byteen_i[b]) begin
          mem_array[mem_req_addr_i][b*8 +: 8] <= mem_req_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Line as seen at the accepting edge. Because the first pipeline stage
  // (or the FIFO itself for LATENCY=1) captures this value at that edge, a
  // later write cannot reach an in-flight read.
  logic [DATA_WIDTH-1:0] rd_line;
  assign rd_line = mem_array[mem_req_addr_i];

  // -------------------------------------------------------------------------
  // Latency pipeline: LATENCY-1 stages, never stalls
  // -------------------------------------------------------------------------
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [TAG_WIDTH-1:0]  push_tag;

  if (LATENCY == 1) begin : g_direct
    // Zero stages: the read goes straight into the FIFO at the accept edge.
    assign push_valid = rd_accept;
    assign push_data  = rd_line;
    assign push_tag   = mem_req_tag_i;
  end else begin : g_pipe
    localparam int STAGES = LATENCY - 1;

    logic [STAGES-1:0]     stage_valid;
    logic [DATA_WIDTH-1:0] stage_data [STAGES];
    logic [TAG_WIDTH-1:0]  stage_tag  [STAGES];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // shifts on the old value of its predecessor, independent of statement
    // order.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stage_valid <= '0;
      end else begin
        stage_valid[0] <= rd_accept;
        for (int s = 1; s < STAGES; s++) begin
          stage_valid[s] <= stage_valid[s-1];
        end
      end
    end

    // Payload needs no reset: it is only consumed when its valid bit is set.
    always_ff @(posedge clk_i) begin
      stage_data[0] <= rd_line;
      stage_tag[0]  <= mem_req_tag_i;
      for (int s = 1; s < STAGES; s++) begin
        stage_data[s] <= stage_data[s-1];
        stage_tag[s]  <= stage_tag[s-1];
      end
    end

    assign push_valid = stage_valid[STAGES-1];
    assign push_data  = stage_data[STAGES-1];
    assign push_tag   = stage_tag[STAGES-1];
  end

  // -------------------------------------------------------------------------
  // Response FIFO
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_data [RSP_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_valid) wr_ptr <= wr_ptr + PTR_INC;
      if (pop)        rd_ptr <= rd_ptr + PTR_INC;
      case ({push_valid, pop})
        2'b10:   fifo_count <= fifo_count + ONE_C;
        2'b01:   fifo_count <= fifo_count - ONE_C;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_valid) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_tag[wr_ptr]  <= push_tag;
    end
  end

  // The head is forced to zero while empty so the outputs read as zero after
  // reset without resetting the FIFO storage. While a response is stalled the
  // head entry and rd_ptr do not move, so the outputs hold.
  assign mem_rsp_valid_o = (fifo_count != '0);
  assign mem_rsp_data_o  = mem_rsp_valid_o ? fifo_data[rd_ptr] : '0;
  assign mem_rsp_tag_o   = mem_rsp_valid_o ? fifo_tag[rd_ptr]  : '0;

  // -------------------------------------------------------------------------
  // Credits: reads accepted and not yet popped, covering pipeline plus FIFO
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] outstanding;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({rd_accept, pop})
        2'b10:   outstanding <= outstanding + ONE_C;
        2'b01:   outstanding <= outstanding - ONE_C;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Writes consume no credit but are held off together with reads, keeping
  // ready independent of the request contents.
  assign mem_req_ready_o = (outstanding < DEPTH_C);

  // -------------------------------------------------------------------------
  // Completion monitor
  // -------------------------------------------------------------------------
`ifdef RAM_DONE_MONITOR_EN
  localparam logic [RAM_ADDR_BITS-1:0] DONE_IDX = RAM_ADDR_BITS'(DONE_ADDR);

  logic done_q;

  // Watching the stored line catches both interface and backdoor writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
    end else if (mem_array[DONE_IDX][31:0] == 32'h1) begin
      done_q <= 1'b1;
    end
  end

  assign done_o = done_q;
`else
  // DONE_ADDR has no consumer in this build; keep it referenced.
  logic [RAM_ADDR_BITS-1:0] unused_done_addr;
  assign unused_done_addr = RAM_ADDR_BITS'(DONE_ADDR);

  assign done_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_pipe.sv
// ---------------------------------------------------------------------------
// tb_ram_pipe
//
// Directed bench for ram_pipe at default parameters (LATENCY=4, depth 8,
// 512-bit lines). Walks through reset values, exact read latency, byte
// enables, credit backpressure with in-order draining, the read-then-write
// hazard, reset with reads in flight, and the completion flag.
// ---------------------------------------------------------------------------
module tb_ram_pipe;

  localparam int AW = 9;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int BW = DW / 8;
  localparam int MAX_WAIT = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_rw = 1'b0;
  logic [BW-1:0] req_byteen = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [TW-1:0] req_tag = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ready = 1'b1;
  logic          done;

  int pass_cnt = 0;
  int check_cnt = 0;

  ram_pipe dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .mem_req_valid_i  (req_valid),
    .mem_req_rw_i     (req_rw),
    .mem_req_byteen_i (req_byteen),
    .mem_req_addr_i   (req_addr),
    .mem_req_data_i   (req_data),
    .mem_req_tag_i    (req_tag),
    .mem_req_ready_o  (req_ready),
    .mem_rsp_valid_o  (rsp_valid),
    .mem_rsp_data_o   (rsp_data),
    .mem_rsp_tag_o    (rsp_tag),
    .mem_rsp_ready_i  (rsp_ready),
    .done_o           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
  endtask

  // Advance past one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [BW-1:0] byteen);
    req_valid  = 1'b1;
    req_rw     = 1'b1;
    req_addr   = addr;
    req_data   = data;
    req_byteen = byteen;
    tick();
    req_valid  = 1'b0;
    req_byteen = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = addr;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits a bounded time for a response, records it, and lets it pop
  // (rsp_ready is expected to be 1).
  task automatic get_rsp(input string name, output logic [DW-1:0] data,
                         output logic [TW-1:0] tag);
    int n = 0;
    while (!rsp_valid && n < MAX_WAIT) begin
      tick();
      n++;
    end
    check({name, "_arrived"}, DW'(rsp_valid), DW'(1));
    data = rsp_data;
    tag  = rsp_tag;
    tick();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    int accepted;
    int stray;

    // ---- Reset values ----
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready",       DW'(req_ready),       DW'(1));
    check("rst_rsp_valid",   DW'(rsp_valid),       DW'(0));
    check("rst_rsp_data",    rsp_data,             DW'(0));
    check("rst_rsp_tag",     DW'(rsp_tag),         DW'(0));
    check("rst_done",        DW'(done),            DW'(0));
    check("rst_outstanding", DW'(dut.outstanding), DW'(0));

    // ---- Exact latency: write line 5 = 0xA5.., read it with tag 3 ----
    do_write(9'd5, {64{8'hA5}}, '1);
    do_read(9'd5, 8'h03);                 // now in cycle t+1
    check("lat_t1_valid", DW'(rsp_valid), DW'(0));
    tick();
    tick();                               // cycle t+3
    check("lat_t3_valid", DW'(rsp_valid), DW'(0));
    tick();                               // cycle t+4
    check("lat_t4_valid", DW'(rsp_valid), DW'(1));
    check("lat_data",     rsp_data,       {64{8'hA5}});
    check("lat_tag",      DW'(rsp_tag),   DW'(8'h03));
    tick();
    check("lat_popped",   DW'(rsp_valid), DW'(0));

    // ---- Byte enables: only bytes 0-3 written ----
    do_write(9'd2, '0, '1);
    do_write(9'd2, '1, BW'(64'hF));
    do_read(9'd2, 8'h07);
    get_rsp("byteen", d, t);
    check("byteen_data", d, DW'(32'hFFFF_FFFF));
    check("byteen_tag",  DW'(t), DW'(8'h07));

    // ---- Backpressure: 10 reads with rsp_ready low, 8 accepted ----
    for (int i = 0; i < 10; i++) begin
      do_write(AW'(10 + i), {16{32'h1000_0000 + 32'(i)}}, '1);
    end
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 8 + 2; i++) begin
      req_valid = 1'b1;
      req_rw    = 1'b0;
      req_addr  = AW'(10 + i);
      req_tag   = TW'(8'h40 + i);
      if (req_ready) accepted++;
      if (i < 8) tick();
      else begin
        // Hold the last two requests one cycle each; they must be refused.
        tick();
      end
    end
    req_valid = 1'b0;
    check("bp_accepted",    DW'(accepted),        DW'(8));
    check("bp_ready_low",   DW'(req_ready),       DW'(0));
    check("bp_outstanding", DW'(dut.outstanding), DW'(8));
    tick();
    tick();
    tick();
    check("bp_head_valid", DW'(rsp_valid), DW'(1));
    check("bp_head_tag",   DW'(rsp_tag),   DW'(8'h40));
    tick();
    tick();
    check("bp_stall_valid", DW'(rsp_valid), DW'(1));
    check("bp_stall_tag",   DW'(rsp_tag),   DW'(8'h40));
    check("bp_stall_data",  rsp_data,       {16{32'h1000_0000}});
    check("bp_ready_still_low", DW'(req_ready), DW'(0));
    rsp_ready = 1'b1;
    tick();                               // first pop
    check("bp_ready_after_pop", DW'(req_ready), DW'(1));
    for (int i = 1; i < 8; i++) begin
      check($sformatf("bp_rsp%0d_valid", i), DW'(rsp_valid), DW'(1));
      check($sformatf("bp_rsp%0d_tag", i),   DW'(rsp_tag),   DW'(8'h40 + i));
      check($sformatf("bp_rsp%0d_data", i),  rsp_data,
            {16{32'h1000_0000 + 32'(i)}});
      tick();
    end
    check("bp_drained", DW'(rsp_valid), DW'(0));
    do_read(9'd18, 8'h48);
    do_read(9'd19, 8'h49);
    get_rsp("bp_late8", d, t);
    check("bp_late8_tag",  DW'(t), DW'(8'h48));
    check("bp_late8_data", d,      {16{32'h1000_0008}});
    get_rsp("bp_late9", d, t);
    check("bp_late9_tag",  DW'(t), DW'(8'h49));
    check("bp_late9_data", d,      {16{32'h1000_0009}});
    check("bp_end_outstanding", DW'(dut.outstanding), DW'(0));

    // ---- Read-then-write hazard on line 7 ----
    do_write(9'd7, {64{8'h11}}, '1);
    do_read(9'd7, 8'h17);
    do_write(9'd7, {64{8'h22}}, '1);
    get_rsp("hz_old", d, t);
    check("hz_old_data", d,      {64{8'h11}});
    check("hz_old_tag",  DW'(t), DW'(8'h17));
    do_read(9'd7, 8'h18);
    get_rsp("hz_new", d, t);
    check("hz_new_data", d, {64{8'h22}});

    // ---- Reset with three reads in flight ----
    do_read(9'd5, 8'h01);
    do_read(9'd7, 8'h02);
    do_read(9'd2, 8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_outstanding", DW'(dut.outstanding), DW'(0));
    check("mr_ready",       DW'(req_ready),       DW'(1));
    check("mr_valid",       DW'(rsp_valid),       DW'(0));
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) stray++;
      tick();
    end
    check("mr_no_stray_rsp", DW'(stray), DW'(0));
    check("mr_mem_line2", dut.mem_array[2], DW'(32'hFFFF_FFFF));
    do_read(9'd7, 8'h21);
    get_rsp("mr_line7", d, t);
    check("mr_line7_data", d, {64{8'h22}});
    do_read(9'd5, 8'h22);
    get_rsp("mr_line5", d, t);
    check("mr_line5_data", d, {64{8'hA5}});

    // ---- Completion flag via interface write to line 496 ----
    do_write(9'd496, DW'(32'h1), BW'(64'hF));
    tick();
`ifdef RAM_DONE_MONITOR_EN
    check("done_set", DW'(done), DW'(1));
    tick();
    tick();
    check("done_sticky", DW'(done), DW'(1));
`else
    check("done_off", DW'(done), DW'(0));
    tick();
    tick();
    check("done_off_later", DW'(done), DW'(0));
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
